// File: rtl/vga_timing_gen.sv
// VGA raster timing: registered pixel/line counters, sync pulses, blank and frame strobe.
// Define VGA_FRAME_COUNT_EN to build the 16-bit completed-frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        en,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic [10:0] drawX,
  output logic [10:0] drawY,
  output logic        frame_clk,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_MAX = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS = 11'(V_VISIBLE);
  localparam logic [10:0] H_SS  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SE  = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_SS  = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SE  = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic        ACT   = (SYNC_POL != 0);

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_q, blank_d;
  logic        fclk_q, fclk_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (rst) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_q == H_MAX) begin
        x_d = '0;
        y_d = (y_q == V_MAX) ? '0 : y_q + 11'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  // Decode from the next position so outputs align with drawX/drawY.
  always_comb begin
    hs_d    = ((x_d >= H_SS) && (x_d < H_SE)) ? ACT : ~ACT;
    vs_d    = ((y_d >= V_SS) && (y_d < V_SE)) ? ACT : ~ACT;
    blank_d = (x_d >= H_VIS) || (y_d >= V_VIS);
    fclk_d  = !rst && en && (x_d == '0) && (y_d == V_VIS);
  end

  always_ff @(posedge pixel_clk) begin
    x_q     <= x_d;
    y_q     <= y_d;
    hs_q    <= hs_d;
    vs_q    <= vs_d;
    blank_q <= blank_d;
    fclk_q  <= fclk_d;
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc_q, fc_d;

  always_comb begin
    fc_d = fc_q + 16'(fclk_d);
    if (rst) fc_d = '0;
  end

  always_ff @(posedge pixel_clk) begin
    fc_q <= fc_d;
  end

  assign frame_count = fc_q;
`else
  assign frame_count = '0;
`endif

  assign drawX     = x_q;
  assign drawY     = y_q;
  assign hs        = hs_q;
  assign vs        = vs_q;
  assign blank     = blank_q;
  assign frame_clk = fclk_q;

  a_total_range: assert property (
    @(posedge pixel_clk) (H_TOTAL <= 2047) && (V_TOTAL <= 2047)
  ) else $error("vga_timing_gen: H/V total exceeds 11-bit counter range");

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing and small-timing instances
// checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b0;

  logic        hs_a, vs_a, blank_a, fclk_a;
  logic [10:0] x_a, y_a;
  logic [15:0] fc_a;
  logic        hs_b, vs_b, blank_b, fclk_b;
  logic [10:0] x_b, y_b;
  logic [15:0] fc_b;

  vga_timing_gen u_a (
    .pixel_clk   (clk),
    .rst         (rst),
    .en          (en),
    .hs          (hs_a),
    .vs          (vs_a),
    .blank       (blank_a),
    .drawX       (x_a),
    .drawY       (y_a),
    .frame_clk   (fclk_a),
    .frame_count (fc_a)
  );

  vga_timing_gen #(
    .H_VISIBLE (20), .H_FP (3), .H_SYNC (4), .H_BP (5),
    .V_VISIBLE (12), .V_FP (2), .V_SYNC (3), .V_BP (4),
    .SYNC_POL  (1)
  ) u_b (
    .pixel_clk   (clk),
    .rst         (rst),
    .en          (en),
    .hs          (hs_b),
    .vs          (vs_b),
    .blank       (blank_b),
    .drawX       (x_b),
    .drawY       (y_b),
    .frame_clk   (fclk_b),
    .frame_count (fc_b)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fclk;
    logic [15:0] fc;
  } obs_t;

  obs_t obs_a, obs_b;
  assign obs_a = {x_a, y_a, hs_a, vs_a, blank_a, fclk_a, fc_a};
  assign obs_b = {x_b, y_b, hs_b, vs_b, blank_b, fclk_b, fc_b};

  int checks = 0;
  int errors = 0;

  longint n      = 0;
  bit     adv    = 1'b0;
  bit     mvalid = 1'b0;

  // Raster position is simply the enabled-cycle count modulo line/frame sizes.
  function automatic obs_t model(input longint cnt, input bit a,
                                 input int hv, input int hf,
                                 input int hsy, input int hb,
                                 input int vv, input int vf,
                                 input int vsy, input int vb,
                                 input bit pol);
    obs_t   e;
    longint ht = longint'(hv + hf + hsy + hb);
    longint vt = longint'(vv + vf + vsy + vb);
    longint fr = ht * vt;
    longint st = longint'(vv) * ht;
    longint p  = cnt % fr;
    longint px = p % ht;
    longint py = p / ht;
    e.x  = 11'(px);
    e.y  = 11'(py);
    e.hs = (px >= hv + hf && px < hv + hf + hsy) ? pol : !pol;
    e.vs = (py >= vv + vf && py < vv + vf + vsy) ? pol : !pol;
    e.blank = (px >= hv) || (py >= vv);
    e.fclk  = a && (p == st);
`ifdef VGA_FRAME_COUNT_EN
    e.fc = (cnt >= st) ? 16'((cnt - st) / fr + 1) : 16'd0;
`else
    e.fc = 16'd0;
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      n      <= 0;
      adv    <= 1'b0;
      mvalid <= 1'b1;
    end else begin
      adv <= en;
      if (en) n <= n + 1;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("model_a", 64'(obs_a),
            64'(model(n, adv, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)));
      check("model_b", 64'(obs_b),
            64'(model(n, adv, 20, 3, 4, 5, 12, 2, 3, 4, 1'b1)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int strobes;
  int last_at;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) tick();
    check("rst_a_pos", 64'({x_a, y_a}), 64'(0));
    check("rst_a_out", 64'({hs_a, vs_a, blank_a, fclk_a, fc_a}),
          64'({1'b1, 1'b1, 1'b0, 1'b0, 16'd0}));
    check("rst_b_out", 64'({hs_b, vs_b, blank_b, fclk_b, fc_b}),
          64'({1'b0, 1'b0, 1'b0, 1'b0, 16'd0}));

    rst = 1'b0;
    en  = 1'b1;
    for (int k = 1; k <= 800; k++) begin
      tick();
      if (k == 655) check("hs_a_655", 64'(hs_a), 64'(1));
      if (k == 656) check("hs_a_656", 64'({x_a, hs_a}), 64'({11'd656, 1'b0}));
      if (k == 751) check("hs_a_751", 64'(hs_a), 64'(0));
      if (k == 752) check("hs_a_752", 64'(hs_a), 64'(1));
      if (k == 799) check("x_a_799", 64'({x_a, y_a}), 64'({11'd799, 11'd0}));
      if (k == 800) check("wrap_a", 64'({x_a, y_a}), 64'({11'd0, 11'd1}));
      if (k == 20)  check("blank_b_20", 64'(blank_b), 64'(1));
      if (k == 23)  check("hs_b_23", 64'(hs_b), 64'(1));
      if (k == 32)  check("wrap_b", 64'({x_b, y_b}), 64'({11'd0, 11'd1}));
    end

    for (int i = 0; i < 20000; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 1999) == 0);
      tick();
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b1;
    repeat (438) tick();
    check("pre_freeze", 64'({x_b, y_b, vs_b}), 64'({11'd22, 11'd13, 1'b0}));
    en = 1'b0;
    repeat (50) tick();
    check("frozen", 64'({x_b, y_b, vs_b, fclk_b}),
          64'({11'd22, 11'd13, 1'b0, 1'b0}));
    en = 1'b1;
    repeat (9) tick();
    check("vs_b_before", 64'(vs_b), 64'(0));
    tick();
    check("vs_b_resume", 64'({x_b, y_b, vs_b}), 64'({11'd0, 11'd14, 1'b1}));

    repeat (54) tick();
    check("mid_vs", 64'({x_b, y_b, vs_b}), 64'({11'd22, 11'd15, 1'b1}));
    rst = 1'b1;
    tick();
    check("rst_mid_b", 64'({x_b, y_b, hs_b, vs_b, blank_b, fc_b}),
          64'({11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 16'd0}));
    check("rst_mid_a", 64'({x_a, y_a, hs_a, vs_a}),
          64'({11'd0, 11'd0, 1'b1, 1'b1}));
    rst = 1'b0;

    strobes = 0;
    last_at = 0;
    for (int k = 1; k <= 2016; k++) begin
      tick();
      if (fclk_b) begin
        if (strobes == 0) check("strobe_first", 64'(k), 64'(384));
        else check("strobe_period", 64'(k - last_at), 64'(672));
        last_at = k;
        strobes++;
      end
    end
    check("strobe_count", 64'(strobes), 64'(3));
`ifdef VGA_FRAME_COUNT_EN
    check("frame_count_b", 64'(fc_b), 64'(3));
`else
    check("frame_count_b", 64'(fc_b), 64'(0));
`endif
    check("frame_count_a", 64'(fc_a), 64'(0));

    en = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
